// File: rtl/mac_cfu.sv
// mac_cfu: custom-function unit with ADD/SUB/MUL/MAC and accumulator access.
// Multiplies use an iterative shift-add datapath that retires BITS_PER_CYCLE
// multiplier bits per cycle, so a MUL/MAC takes DATA_W/BITS_PER_CYCLE cycles.
// Optional feature: define MAC_CFU_SAT_EN to saturate MAC results as signed
// two's-complement values; without it MAC results wrap modulo 2^DATA_W.
module mac_cfu #(
  parameter int DATA_W         = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [9:0]        cmd_payload_function_id,
  input  logic [DATA_W-1:0] cmd_payload_inputs_0,
  input  logic [DATA_W-1:0] cmd_payload_inputs_1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_payload_outputs_0
);

  localparam int STEPS = DATA_W / BITS_PER_CYCLE;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    RESP
  } state_t;

  state_t            state_reg, state_next;
  logic              mac_op_reg, mac_op_next;
  logic [DATA_W-1:0] mcand_reg, mcand_next;
  logic [DATA_W-1:0] mplier_reg, mplier_next;
  logic [DATA_W-1:0] prod_reg, prod_next;
  logic [CNT_W-1:0]  step_reg, step_next;
  logic [DATA_W-1:0] acc_reg, acc_next;
  logic [DATA_W-1:0] result_reg, result_next;

  logic [DATA_W-1:0] pp [BITS_PER_CYCLE];
  logic [DATA_W-1:0] prod_step;
  logic [DATA_W-1:0] mac_value;

  // Opcode field is only 3 bits wide; the upper function_id bits are don't-care.
  logic unused_func_bits;
  assign unused_func_bits = ^cmd_payload_function_id[9:3];

  // One partial product per multiplier bit retired this cycle.
  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
      assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
    end
  endgenerate

  // Running product after adding this cycle's partial products.
  always_comb begin
    prod_step = prod_reg;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      prod_step = prod_step + pp[i];
    end
  end

`ifdef MAC_CFU_SAT_EN
  logic [DATA_W-1:0] mac_sum;
  logic              mac_ovf;

  // Signed accumulate; clamp when both addends share a sign the sum lost.
  always_comb begin
    mac_sum = acc_reg + prod_step;
    mac_ovf = (acc_reg[DATA_W-1] == prod_step[DATA_W-1]) &&
              (mac_sum[DATA_W-1] != acc_reg[DATA_W-1]);
    mac_value = mac_sum;
    if (mac_ovf) begin
      mac_value = acc_reg[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                    : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  // Plain modular accumulate.
  always_comb begin
    mac_value = acc_reg + prod_step;
  end
`endif

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      mac_op_reg <= 1'b0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      prod_reg   <= '0;
      step_reg   <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      mac_op_reg <= mac_op_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      prod_reg   <= prod_next;
      step_reg   <= step_next;
      acc_reg    <= acc_next;
      result_reg <= result_next;
    end
  end

  // Next-state and datapath decode: ALU ops answer in one cycle, MUL/MAC iterate.
  always_comb begin
    state_next  = state_reg;
    mac_op_next = mac_op_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    prod_next   = prod_reg;
    step_next   = step_reg;
    acc_next    = acc_reg;
    result_next = result_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          state_next = RESP;
          case (cmd_payload_function_id[2:0])
            3'd0: result_next = cmd_payload_inputs_0 + cmd_payload_inputs_1;
            3'd1: result_next = cmd_payload_inputs_0 - cmd_payload_inputs_1;
            3'd2, 3'd3: begin
              state_next  = MUL;
              mac_op_next = cmd_payload_function_id[0];
              mcand_next  = cmd_payload_inputs_0;
              mplier_next = cmd_payload_inputs_1;
              prod_next   = '0;
              step_next   = '0;
            end
            3'd4: result_next = acc_reg;
            3'd5: begin
              result_next = acc_reg;
              acc_next    = '0;
            end
            3'd6: begin
              result_next = cmd_payload_inputs_0;
              acc_next    = cmd_payload_inputs_0;
            end
            default: result_next = '0;
          endcase
        end
      end
      MUL: begin
        prod_next   = prod_step;
        mcand_next  = mcand_reg << BITS_PER_CYCLE;
        mplier_next = mplier_reg >> BITS_PER_CYCLE;
        step_next   = step_reg + CNT_W'(1);
        if (step_reg == LAST_STEP) begin
          state_next = RESP;
          if (mac_op_reg) begin
            acc_next    = mac_value;
            result_next = mac_value;
          end else begin
            result_next = prod_step;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign cmd_ready             = (state_reg == IDLE);
  assign rsp_valid             = (state_reg == RESP);
  assign rsp_payload_outputs_0 = result_reg;

endmodule

// File: tb/tb_mac_cfu.sv
// tb_mac_cfu: directed vectors with a scoreboard queue; a monitor compares
// each response's value and arrival cycle against the queued expectation.
module tb_mac_cfu;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_MAC = 3'd3;
  localparam logic [2:0] OP_RD = 3'd4, OP_CLR = 3'd5, OP_SET = 3'd6, OP_NOP = 3'd7;

`ifdef MAC_CFU_SAT_EN
  localparam logic [31:0] SAT_EXP = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] SAT_EXP = 32'h8000_0000;
`endif

  logic        clk;
  logic        reset;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [9:0]  func_id;
  logic [31:0] in0, in1, rsp_data;

  logic        c4_valid, c4_ready, c4_rsp_valid, c4_rsp_ready;
  logic [9:0]  c4_func;
  logic [31:0] c4_in0, c4_in1, c4_rsp_data;

  typedef struct {
    logic [31:0] result;
    int          exp_cyc;
    int          tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   tag_cnt = 0;

  mac_cfu #(.DATA_W(32), .BITS_PER_CYCLE(1)) u_dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_payload_function_id(func_id),
    .cmd_payload_inputs_0(in0), .cmd_payload_inputs_1(in1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_payload_outputs_0(rsp_data)
  );

  mac_cfu #(.DATA_W(32), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .cmd_valid(c4_valid), .cmd_ready(c4_ready),
    .cmd_payload_function_id(c4_func),
    .cmd_payload_inputs_0(c4_in0), .cmd_payload_inputs_1(c4_in1),
    .rsp_valid(c4_rsp_valid), .rsp_ready(c4_rsp_ready),
    .rsp_payload_outputs_0(c4_rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Generic scalar check used for direct observations.
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, want);
    end
  endtask

  // Monitor: compare each new response against the head of the scoreboard.
  initial begin : monitor
    bit   armed;
    exp_t e;
    armed = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp_valid && !armed) begin
        armed = 1'b1;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp got=%h required=none", rsp_data);
        end else begin
          e = sb_q.pop_front();
          $display("rsp #%0d result=%h expected=%h cycle=%0d expected_cycle=%0d",
                   e.tag, rsp_data, e.result, cyc, e.exp_cyc);
          check($sformatf("rsp%0d_value", e.tag), rsp_data, e.result);
          check($sformatf("rsp%0d_latency", e.tag), 32'(cyc), 32'(e.exp_cyc));
        end
      end else if (!rsp_valid) begin
        armed = 1'b0;
      end
    end
  end

  // Offer one command, and queue its expected result and arrival cycle.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] want, input int lat);
    int   n;
    exp_t e;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL cmd_ready_timeout got=0 required=1");
      return;
    end
    cmd_valid = 1'b1;
    func_id   = {7'h55, op};
    in0       = a;
    in1       = b;
    @(posedge clk);
    #1;
    e.result  = want;
    e.exp_cyc = cyc + lat - 1;
    e.tag     = tag_cnt;
    tag_cnt++;
    sb_q.push_back(e);
    cmd_valid = 1'b0;
    in0       = $urandom;
    in1       = $urandom;
  endtask

  // Wait until the DUT is back in IDLE with no pending response.
  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(cmd_ready && !rsp_valid) && n < 200);
    if (!(cmd_ready && !rsp_valid)) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got=busy required=idle");
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] want, input int lat);
    send(op, a, b, want, lat);
    drain();
  endtask

  // Multiply on the 4-bits-per-cycle instance and check value and latency.
  task automatic mul4(input logic [31:0] a, input logic [31:0] b, input logic [31:0] want);
    int n;
    @(negedge clk);
    c4_valid = 1'b1;
    c4_func  = {7'h00, OP_MUL};
    c4_in0   = a;
    c4_in1   = b;
    @(posedge clk);
    #1;
    c4_valid = 1'b0;
    n = 1;
    while (!c4_rsp_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    $display("bpc4 mul %h*%h result=%h latency=%0d", a, b, c4_rsp_data, n);
    check("bpc4_latency", 32'(n), 32'd9);
    check("bpc4_value", c4_rsp_data, want);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset = 1'b1;
    cmd_valid = 1'b0; func_id = '0; in0 = '0; in1 = '0; rsp_ready = 1'b1;
    c4_valid = 1'b0; c4_func = '0; c4_in0 = '0; c4_in1 = '0; c4_rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_result", rsp_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);

    run(OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1);
    run(OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
    run(OP_MUL, 32'd7, 32'd6, 32'd42, 33);
    run(OP_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 33);
    run(OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0, 33);
    run(OP_SET, 32'h7FFF_FFF0, 32'hDEAD_BEEF, 32'h7FFF_FFF0, 1);
    run(OP_MAC, 32'h10, 32'h1, SAT_EXP, 33);
    run(OP_RD, 32'h1234, 32'h5678, SAT_EXP, 1);
    run(OP_SET, 32'd100, 32'd0, 32'd100, 1);
    run(OP_CLR, 32'd9, 32'd9, 32'd100, 1);
    run(OP_RD, 32'd0, 32'd0, 32'd0, 1);
    run(OP_NOP, 32'd5, 32'd9, 32'd0, 1);
    run(OP_SET, 32'd10, 32'd0, 32'd10, 1);
    run(OP_MAC, 32'd3, 32'd4, 32'd22, 33);
    run(OP_NOP, 32'd1, 32'd1, 32'd0, 1);
    run(OP_RD, 32'd0, 32'd0, 32'd22, 1);

    // Back-pressure: response must hold while new commands are offered.
    rsp_ready = 1'b0;
    send(OP_ADD, 32'd1, 32'd2, 32'd3, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_result", rsp_data, 32'd3);
      check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      cmd_valid = ~cmd_valid;
      func_id   = {7'h00, OP_ADD};
      in0       = 32'd100;
      in1       = 32'd200;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();
    run(OP_SUB, 32'd50, 32'd8, 32'd42, 1);

    // Reset in the middle of a MAC: nothing comes back and acc is cleared.
    run(OP_SET, 32'h0000_1234, 32'd0, 32'h0000_1234, 1);
    @(negedge clk);
    cmd_valid = 1'b1;
    func_id   = {7'h00, OP_MAC};
    in0       = 32'd3;
    in1       = 32'd5;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midmul_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midmul_reset_result", rsp_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midmul_post_cmd_ready", 32'(cmd_ready), 32'd1);
    run(OP_RD, 32'd0, 32'd0, 32'd0, 1);
    run(OP_MUL, 32'd3, 32'd3, 32'd9, 33);

    mul4(32'd7, 32'd6, 32'd42);
    mul4(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_cfu.md
MAC_CFU -- requirements
Module: mac_cfu

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result/accumulator width in bits (even, >= 8).
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 1, multiplier bits retired per MUL cycle; SHALL divide DATA_W; STEPS = DATA_W/BITS_PER_CYCLE.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command can be accepted.
REQ-007 SHALL have port cmd_payload_function_id  input  10  opcode in bits [2:0]; bits [9:3] ignored.
REQ-008 SHALL have port cmd_payload_inputs_0  input  DATA_W  operand A.
REQ-009 SHALL have port cmd_payload_inputs_1  input  DATA_W  operand B.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  response consumed.
REQ-012 SHALL have port rsp_payload_outputs_0  output  DATA_W  result.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, RESP; cmd_ready = 1 only in IDLE.
REQ-014 SHALL accept a command on a rising edge with cmd_valid && cmd_ready, latching opcode and operands.
REQ-015 SHALL decode opcodes: 0 ADD A+B; 1 SUB A-B; 2 MUL low DATA_W bits of A*B; 3 MAC acc <= acc + low(A*B), result = new acc; 4 RDACC result = acc; 5 CLRACC result = old acc, acc <= 0; 6 SETACC acc <= A, result = A; 7 result = 0, no side effect.
REQ-016 SHALL wrap all ADD/SUB/MUL results modulo 2^DATA_W.
REQ-017 SHALL, for opcodes 0,1,4,5,6,7, go IDLE->RESP on the accept edge: rsp_valid high in the following cycle (1-cycle latency).
REQ-018 SHALL, for opcodes 2,3, go IDLE->MUL on the accept edge, run iterative shift-add for exactly STEPS cycles, then MUL->RESP; rsp_valid high STEPS+1 cycles after accept.
REQ-019 SHALL update acc for MAC only on the MUL->RESP edge.
REQ-020 SHALL hold rsp_payload_outputs_0 and rsp_valid stable in RESP while rsp_ready = 0.
REQ-021 SHALL go RESP->IDLE on an edge with rsp_ready = 1; rsp_valid low the next cycle; no back-to-back accept in that same edge (cmd_ready is 0 in RESP).
REQ-022 SHALL ignore cmd_valid and all inputs in MUL and RESP.
REQ-023 SHALL not change rsp_payload_outputs_0 except on transitions into RESP.

Reset
REQ-024 SHALL, on reset asserted at any time incl. mid-MUL or in RESP, immediately force state IDLE, rsp_valid = 0, rsp_payload_outputs_0 = 0, acc = 0, internal multiplier registers = 0.
REQ-025 SHALL present cmd_ready = 1 on the first cycle after reset deassertion.
REQ-026 SHALL discard any in-flight operation on reset; no response is produced for it.

Configuration
REQ-027 SHALL, when macro MAC_CFU_SAT_EN is defined, treat acc and low(A*B) as two's-complement and saturate MAC results to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-028 SHALL, when MAC_CFU_SAT_EN is undefined, wrap MAC results modulo 2^DATA_W; no saturation logic present.
REQ-029 SHALL leave opcodes other than MAC unaffected by MAC_CFU_SAT_EN.

Verification (DATA_W=32, BITS_PER_CYCLE=1 unless noted)
REQ-030 SHALL cover ADD 0xFFFFFFFF+1 -> 0x00000000, rsp_valid 1 cycle after accept; SUB 5-7 -> 0xFFFFFFFE.
REQ-031 SHALL cover MUL 7*6 -> 42 with rsp_valid exactly 33 cycles after accept; repeat with BITS_PER_CYCLE=4 -> 9 cycles.
REQ-032 SHALL cover SETACC 0x7FFFFFF0 then MAC 0x10*1 -> 0x7FFFFFFF with MAC_CFU_SAT_EN, 0x80000000 without; RDACC returns same value.
REQ-033 SHALL cover CLRACC after acc=100 -> result 100, then RDACC -> 0.
REQ-034 SHALL cover rsp_ready held 0 for 5 cycles: rsp_valid and result stable, cmd_ready 0, cmd_valid pulses ignored.
REQ-035 SHALL cover reset asserted mid-MUL (cycle 10 of MAC): rsp_valid 0 immediately, acc 0, next MUL 3*3 -> 9.
